// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between the VGA display fetch path and a host
// pixel writer. A fetch engine streams the frame sequentially into a small prefetch FIFO
// that the timing generator pops one pixel per cycle. The host gets every RAM slot that is
// not needed to keep the FIFO safely filled.
//
// Ports
//   i_clk, i_reset           pixel clock, synchronous active-high reset
//   i_frame_start            one-cycle pulse before the first visible pixel of a frame
//   i_pix_pop                display consumes the FIFO head this cycle
//   o_pix_valid, o_pix_data  FIFO not empty / FIFO head (0 when empty)
//   o_underrun               sticky: pop seen while the FIFO was empty
//   i_wr_valid, o_wr_ready   host write handshake
//   i_wr_addr, i_wr_data     host write address / data
//   o_mem_en, o_mem_we       RAM access this cycle / 1=write 0=read
//   o_mem_addr, o_mem_wdata  RAM address / write data
//   i_mem_rdata              RAM read data, valid one cycle after a read
//
// state   | meaning
// S_IDLE  | after reset, waiting for the first frame_start
// S_FETCH | streaming fetch_addr 0..FB_WORDS-1 into the FIFO
// S_DONE  | whole frame fetched, host owns every slot until frame_start
module vga_fb_arbiter #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 15,
  parameter int FB_WORDS   = 19200,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_start,
  input  logic              i_pix_pop,
  output logic              o_pix_valid,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_underrun,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  localparam logic [OCC_W-1:0]  LOW_WM_C = OCC_W'(LOW_WM);
  localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              r_inflight;
  logic              r_underrun;

  logic [OCC_W-1:0]  w_occ;
  logic              w_host_wr;
  logic              w_fetch_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_pop_empty;

  // Counting the read in flight keeps the FIFO from ever overflowing.
  assign w_occ = OCC_W'(r_level) + OCC_W'(r_inflight);

  // frame_start discards the returning read and masks any same-cycle pop.
  assign w_push      = r_inflight && !i_frame_start;
  assign w_pop       = i_pix_pop && !i_frame_start && (r_level != '0);
  assign w_pop_empty = i_pix_pop && !i_frame_start && (r_level == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_wr_ready  = 1'b1;
    w_host_wr   = 1'b0;
    w_fetch_rd  = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_fetch_addr;
    o_mem_wdata = '0;

    // Host is held off only while the display side is close to starving.
    if (r_state == S_FETCH && w_occ < LOW_WM_C) begin
      o_wr_ready = 1'b0;
    end
    w_host_wr  = i_wr_valid && o_wr_ready;
    w_fetch_rd = !w_host_wr && (r_state == S_FETCH) && (w_occ < DEPTH_C);

    if (w_host_wr) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = i_wr_addr;
      o_mem_wdata = i_wr_data;
    end else if (w_fetch_rd) begin
      o_mem_en = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_frame_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (i_frame_start) begin
          w_state_nxt = S_FETCH;
        end else if (w_fetch_rd && r_fetch_addr == FB_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_frame_start) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_fetch_addr <= '0;
      r_inflight   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_pop_empty) r_underrun <= 1'b1;
      if (i_frame_start) begin
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_level      <= '0;
        r_fetch_addr <= '0;
        r_inflight   <= 1'b0;
      end else begin
        r_inflight <= w_fetch_rd;
        if (w_fetch_rd) r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
        if (w_push)     r_wptr       <= r_wptr + PTR_W'(1);
        if (w_pop)      r_rptr       <= r_rptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // Storage needs no reset; the head is gated by the level.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr] <= i_mem_rdata;
  end

  assign o_pix_valid = (r_level != '0);
  assign o_pix_data  = o_pix_valid ? r_fifo[r_rptr] : '0;
  assign o_underrun  = r_underrun;

endmodule
